// File: rtl/nn_pkg.sv
// Shared types and default layer constants for the MNIST fully-connected layer feeders.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int TICK_W = 10;

  // 784 -> 20 -> 20 -> 10 network
  localparam int L1_N_IN  = 784;
  localparam int L1_N_OUT = 20;
  localparam int L2_N_IN  = 20;
  localparam int L2_N_OUT = 20;
  localparam int L3_N_IN  = 20;
  localparam int L3_N_OUT = 10;

  localparam int DEF_MEM_LAT   = 2;
  localparam int DEF_BIAS_TICK = 3;
  localparam int DEF_ACC_LAT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feed_state_t;

  // Tick on which the neuron outputs are stable and get captured.
  function automatic int t_cap(input int n_in, input int bias_tick, input int acc_lat);
    return bias_tick + n_in + acc_lat;
  endfunction

endpackage

// File: rtl/layer_addr_gen.sv
// Read-address generator for one layer pass: issues buffer/ROM reads and delays
// the valid and bias-row flags so they line up with the returned data.
module layer_addr_gen
  import nn_pkg::*;
#(
  parameter int N_IN      = L1_N_IN,
  parameter int MEM_LAT   = DEF_MEM_LAT,
  parameter int BIAS_TICK = DEF_BIAS_TICK,
  parameter int XA_W      = $clog2(N_IN),
  parameter int WA_W      = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic [TICK_W-1:0] tick,
  output logic              rd_en,
  output logic [XA_W-1:0]   x_addr,
  output logic [WA_W-1:0]   w_addr,
  output logic              data_valid,
  output logic              bias_sel
);

  localparam int K0 = BIAS_TICK - MEM_LAT;

  logic [TICK_W-1:0]  row;
  logic               in_win;
  logic [XA_W-1:0]    x_addr_q;
  logic [WA_W-1:0]    w_addr_q;
  logic [MEM_LAT-1:0] v_pipe;
  logic [MEM_LAT-1:0] b_pipe;

  // Ticks below K0 wrap to a row far above N_IN, so one compare bounds both ends.
  assign row    = tick - TICK_W'(K0);
  assign in_win = active && (row <= TICK_W'(N_IN));
  assign rd_en  = in_win;

  always_comb begin
    w_addr = w_addr_q;
    x_addr = x_addr_q;
    if (in_win) begin
      w_addr = WA_W'(row);
      x_addr = (row == '0) ? '0 : XA_W'(row - TICK_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_addr_q <= '0;
      w_addr_q <= '0;
      v_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      x_addr_q <= x_addr;
      w_addr_q <= w_addr;
      if (!active) begin
        v_pipe <= '0;
        b_pipe <= '0;
      end else begin
        v_pipe[0] <= in_win;
        b_pipe[0] <= in_win && (row == '0);
        for (int i = 1; i < MEM_LAT; i++) begin
          v_pipe[i] <= v_pipe[i-1];
          b_pipe[i] <= b_pipe[i-1];
        end
      end
    end
  end

  assign data_valid = v_pipe[MEM_LAT-1];
  assign bias_sel   = b_pipe[MEM_LAT-1];

endmodule

// File: rtl/layer_feed_ctrl.sv
// Feeding side of one fully-connected layer: sequences a pass over N_OUT parallel
// neurons, streams latency-aligned X/W pairs, and captures Z when the MAC pipe drains.
module layer_feed_ctrl
  import nn_pkg::*;
#(
  parameter int N_IN      = L1_N_IN,
  parameter int N_OUT     = L1_N_OUT,
  parameter int MEM_LAT   = DEF_MEM_LAT,
  parameter int BIAS_TICK = DEF_BIAS_TICK,
  parameter int ACC_LAT   = DEF_ACC_LAT,
  parameter int XA_W      = $clog2(N_IN),
  parameter int WA_W      = $clog2(N_IN + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Active,
  output logic [TICK_W-1:0]       Tick,
  output logic                    Rd_en,
  output logic [XA_W-1:0]         X_addr,
  output logic [WA_W-1:0]         W_addr,
  input  logic [DATA_W-1:0]       X_rdata,
  input  logic [N_OUT*DATA_W-1:0] W_rdata,
  output logic [DATA_W-1:0]       X,
  output logic [N_OUT*DATA_W-1:0] W,
  input  logic [N_OUT*DATA_W-1:0] Z_in,
  output logic [N_OUT*DATA_W-1:0] Z_out,
  output logic                    Z_valid,
  output feed_state_t             State_dbg
);

  localparam int T_CAP = t_cap(N_IN, BIAS_TICK, ACC_LAT);

  if ((T_CAP + 1 >= (1 << TICK_W)) || (MEM_LAT > BIAS_TICK) || (MEM_LAT < 1)) begin : g_cfg_err
    $error("layer_feed_ctrl: T_CAP must fit Tick and 1 <= MEM_LAT <= BIAS_TICK");
  end

  feed_state_t       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              accept, capture;
  logic              data_valid, bias_sel;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  // DONE is the mandatory Active=0 clear cycle; a held Start restarts straight from it.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          tick_d  = '0;
        end
      end
      RUN: begin
        if (tick_q == TICK_W'(T_CAP)) begin
          state_d = DONE;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      DONE: begin
        tick_d  = '0;
        state_d = Start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign Active    = (state_q == RUN);
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign Tick      = tick_q;
  assign State_dbg = state_q;
  assign accept    = Start && (state_q != RUN);
  assign capture   = (state_q == RUN) && (tick_q == TICK_W'(T_CAP));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Z_out   <= '0;
      Z_valid <= 1'b0;
    end else begin
      if (capture) begin
        Z_out   <= Z_in;
        Z_valid <= 1'b1;
      end else if (accept) begin
        Z_valid <= 1'b0;
      end
    end
  end

  layer_addr_gen #(
    .N_IN      (N_IN),
    .MEM_LAT   (MEM_LAT),
    .BIAS_TICK (BIAS_TICK),
    .XA_W      (XA_W),
    .WA_W      (WA_W)
  ) u_addr_gen (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .active     (Active),
    .tick       (tick_q),
    .rd_en      (Rd_en),
    .x_addr     (X_addr),
    .w_addr     (W_addr),
    .data_valid (data_valid),
    .bias_sel   (bias_sel)
  );

  // On the bias row the neurons substitute their own x, so X stays zero.
  always_comb begin
    X = '0;
    W = '0;
    if (Active && data_valid) begin
      W = W_rdata;
      if (!bias_sel) X = X_rdata;
    end
  end

endmodule

// File: tb/tb_layer_feed_ctrl.sv
// Directed bench for layer_feed_ctrl: a small N_IN=4 layer with a latency-2 memory model,
// plus a default-sized instance for full-pass timing.
module tb_layer_feed_ctrl;
  import nn_pkg::*;

  localparam int N_IN = 4;
  localparam int N_OUT = 2;
  localparam int XA_W = 2;
  localparam int WA_W = 3;
  localparam int XB_W = 10;
  localparam int WB_W = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic                start = 1'b0;
  logic                busy, done, active, rd_en, z_valid;
  logic [TICK_W-1:0]   tick;
  logic [XA_W-1:0]     x_addr;
  logic [WA_W-1:0]     w_addr;
  logic [15:0]         x_rdata, x;
  logic [31:0]         w_rdata, w, z_in, z_out;
  feed_state_t         state_dbg;

  // default-depth instance
  logic                start_b = 1'b0;
  logic                busy_b, done_b, active_b, rd_en_b, z_valid_b;
  logic [TICK_W-1:0]   tick_b;
  logic [XB_W-1:0]     x_addr_b;
  logic [WB_W-1:0]     w_addr_b;
  logic [15:0]         x_b;
  logic [31:0]         w_b, z_out_b;
  feed_state_t         state_dbg_b;

  layer_feed_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .MEM_LAT(2), .BIAS_TICK(3), .ACC_LAT(2)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Busy(busy), .Done(done), .Active(active),
    .Tick(tick), .Rd_en(rd_en), .X_addr(x_addr), .W_addr(w_addr), .X_rdata(x_rdata),
    .W_rdata(w_rdata), .X(x), .W(w), .Z_in(z_in), .Z_out(z_out), .Z_valid(z_valid),
    .State_dbg(state_dbg)
  );

  layer_feed_ctrl #(.N_IN(784), .N_OUT(N_OUT)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Start(start_b), .Busy(busy_b), .Done(done_b), .Active(active_b),
    .Tick(tick_b), .Rd_en(rd_en_b), .X_addr(x_addr_b), .W_addr(w_addr_b), .X_rdata(16'h0001),
    .W_rdata(32'h0001_0001), .X(x_b), .W(w_b), .Z_in(32'h1111_2222), .Z_out(z_out_b),
    .Z_valid(z_valid_b), .State_dbg(state_dbg_b)
  );

  // latency-2 memory model; invalid slots return junk the DUT must mask
  logic s1_v = 1'b0, s2_v = 1'b0;
  logic [WA_W-1:0] s1_row = '0, s2_row = '0;
  logic [XA_W-1:0] s1_xa = '0, s2_xa = '0;
  always @(posedge clk) begin
    s1_v <= rd_en;  s1_row <= w_addr;  s1_xa <= x_addr;
    s2_v <= s1_v;   s2_row <= s1_row;  s2_xa <= s1_xa;
  end
  assign w_rdata = s2_v ? {16'(s2_row * 2 + 1), 16'(s2_row * 2)} : 32'hDEAD_BEEF;
  assign x_rdata = s2_v ? 16'(10 + s2_xa) : 16'hBAD0;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pass_exp();
    exp_q.push_back({16'h0000, 16'd1, 16'd0});
    for (int i = 0; i < N_IN; i++)
      exp_q.push_back({16'(10 + i), 16'(2 * i + 3), 16'(2 * i + 2)});
  endtask

  // Drive Start for one edge from a negedge, then check every cycle through DONE.
  task automatic run_checked_pass(input logic [31:0] zcap);
    int et;
    logic ea, er;
    start = 1'b1;
    push_pass_exp();
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      z_in = (c == 10) ? zcap : $urandom;
      ea = (c <= 10);
      et = ea ? c - 1 : 0;
      er = ea && (et >= 1) && (et <= 5);
      chk("active", active, ea);
      chk("busy", busy, ea);
      chk("tick", tick, et);
      chk("done", done, c == 11);
      chk("z_valid", z_valid, c == 11);
      chk("rd_en", rd_en, er);
      if (er) begin
        chk("w_addr", w_addr, et - 1);
        chk("x_addr", x_addr, (et <= 2) ? 0 : et - 2);
      end
      if (x != 16'h0 || w != 32'h0) begin
        if (exp_q.size() == 0) chk("sb_extra_xw", {x, w}, 48'h0);
        else chk("sb_xw", {x, w}, exp_q.pop_front());
      end
      if (c == 11) begin
        chk("z_out", z_out, zcap);
        chk("w_addr_hold", w_addr, 4);
        chk("x_addr_hold", x_addr, 3);
        chk("state_done", state_dbg, DONE);
      end
    end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int done_cyc[$];
    int low_cnt, rd_cnt, xw_cnt, last_xw, done_at;
    z_in = 32'h0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_active", active, 0);
    chk("rst_tick", tick, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", {x_addr, w_addr}, 0);
    chk("rst_xw", {x, w}, 0);
    chk("rst_z", {z_valid, z_out}, 0);
    chk("rst_state", state_dbg, IDLE);
    chk("rst_b", {busy_b, active_b, rd_en_b, tick_b, z_valid_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal pass, then Z holds in IDLE
    run_checked_pass(32'hABCD_1234);
    repeat (3) begin
      @(negedge clk);
      z_in = $urandom;
      chk("idle_z_out_hold", z_out, 32'hABCD_1234);
      chk("idle_z_valid_hold", z_valid, 1);
      chk("idle_active", active, 0);
    end

    // async reset mid-pass at Tick 5
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_tick", tick, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_active", active, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_state", state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_checked_pass(32'h5A5A_0F0F);
    @(negedge clk);

    // Start pulses during RUN are ignored
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 7);
      if (done) done_at = c;
      if (c == 8) chk("run_pulse_tick", tick, 7);
      if (c == 12) chk("run_pulse_idle", active, 0);
    end
    chk("run_pulse_done_cycle", done_at, 11);

    // Start held: back-to-back passes with one clear cycle between
    start = 1'b1;
    low_cnt = 0;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (c == 22) start = 1'b0;
      if (done) done_cyc.push_back(c);
      if (c <= 22 && !active) low_cnt++;
      if (c == 12) chk("b2b_restart_tick", {active, tick}, {1'b1, 10'd0});
      if (c == 23) chk("b2b_idle", active, 0);
    end
    chk("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("b2b_done1", done_cyc[0], 11);
      chk("b2b_done2", done_cyc[1], 22);
    end
    chk("b2b_low_cycles", low_cnt, 2);

    // default-depth pass
    start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    rd_cnt = 0; xw_cnt = 0; last_xw = -1; done_at = -1;
    for (int c = 1; c <= 800 && done_at < 0; c++) begin
      @(negedge clk);
      if (rd_en_b) rd_cnt++;
      if (w_b != 32'h0) begin
        xw_cnt++;
        last_xw = int'(tick_b);
      end
      if (done_b) done_at = c;
    end
    chk("def_done_cycle", done_at, 791);
    chk("def_rd_cycles", rd_cnt, 785);
    chk("def_xw_cycles", xw_cnt, 785);
    chk("def_last_xw_tick", last_xw, 787);
    chk("def_z_out", {z_valid_b, z_out_b}, {1'b1, 32'h1111_2222});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
